// File: rtl/ysyx_decode_pkg.sv
// ysyx_decode_pkg
//   Shared definitions for the NPC instruction-decode stage:
//   - RISC-V major opcode constants
//   - typed encodings for ALU control, branch type, register-file write
//     source, data-memory read and write selects
//   - decode_bundle_t: the XLEN-independent part of a decoded instruction.
//     PC and immediate are XLEN wide and are carried separately.
package ysyx_decode_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_32    = 7'b0111011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  // bit4=0: base ALU ops; bit4=1: M-extension op with funct3 in bits [2:0]
  typedef enum logic [4:0] {
    ALU_ADD    = 5'b00000,
    ALU_SLL    = 5'b00001,
    ALU_SLT    = 5'b00010,
    ALU_SLTU   = 5'b00011,
    ALU_XOR    = 5'b00100,
    ALU_SRL    = 5'b00101,
    ALU_OR     = 5'b00110,
    ALU_AND    = 5'b00111,
    ALU_SUB    = 5'b01000,
    ALU_SRA    = 5'b01101,
    ALU_LUI    = 5'b01110,
    ALU_MUL    = 5'b10000,
    ALU_MULH   = 5'b10001,
    ALU_MULHSU = 5'b10010,
    ALU_MULHU  = 5'b10011,
    ALU_DIV    = 5'b10100,
    ALU_DIVU   = 5'b10101,
    ALU_REM    = 5'b10110,
    ALU_REMU   = 5'b10111
  } alu_ctrl_e;

  typedef enum logic [2:0] {
    BR_NONE = 3'b000,
    BR_BEQ  = 3'b010,
    BR_BNE  = 3'b011,
    BR_BLT  = 3'b100,
    BR_BGE  = 3'b101,
    BR_BLTU = 3'b110,
    BR_BGEU = 3'b111
  } br_type_e;

  typedef enum logic [1:0] {
    RF_NONE = 2'b00,
    RF_PC4  = 2'b01,
    RF_ALU  = 2'b10,
    RF_MEM  = 2'b11
  } rf_wr_sel_e;

  typedef enum logic [2:0] {
    DM_RD_NONE = 3'b000,
    DM_RD_LB   = 3'b001,
    DM_RD_LBU  = 3'b010,
    DM_RD_LH   = 3'b011,
    DM_RD_LHU  = 3'b100,
    DM_RD_LW   = 3'b101,
    DM_RD_LWU  = 3'b110,
    DM_RD_LD   = 3'b111
  } dm_rd_sel_e;

  typedef enum logic [2:0] {
    DM_WR_NONE = 3'b000,
    DM_WR_SB   = 3'b001,
    DM_WR_SH   = 3'b010,
    DM_WR_SW   = 3'b011,
    DM_WR_SD   = 3'b100
  } dm_wr_sel_e;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       rf_wr_en;
    rf_wr_sel_e rf_wr_sel;
    logic       do_jump;
    br_type_e   br_type;
    logic       alu_a_sel;  // 0 = pc, 1 = rs1
    logic       alu_b_sel;  // 0 = rs2, 1 = imm
    alu_ctrl_e  alu_ctrl;
    logic       word;
    dm_rd_sel_e dm_rd_sel;
    dm_wr_sel_e dm_wr_sel;
    logic       illegal;
    logic       ecall;
    logic       ebreak;
  } decode_bundle_t;

endpackage

// File: rtl/ysyx_decode_comb.sv
// ysyx_decode_comb
//   Purely combinational RV32I/RV64I (+ optional M) instruction decoder.
//   Ports:
//     inst   in   32    instruction word
//     bundle out  -     decoded control fields (decode_bundle_t)
//     imm    out  XLEN  sign-extended immediate for the instruction format
//   XLEN=64 enables ld/lwu/sd and the *W ops; HAS_M!=0 enables M ops.
module ysyx_decode_comb
  import ysyx_decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int HAS_M = 0
) (
  input  logic [31:0]     inst,
  output decode_bundle_t  bundle,
  output logic [XLEN-1:0] imm
);

  localparam bit IS_RV64 = (XLEN == 64);
  localparam bit M_ON    = (HAS_M != 0);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       is_op32;

  assign opcode  = inst[6:0];
  assign funct3  = inst[14:12];
  assign funct7  = inst[31:25];
  assign is_op32 = (opcode == OPC_OP_32);

  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  // Casting a signed operand up to XLEN sign-extends from inst[31].
  assign imm_i = XLEN'($signed(inst[31:20]));
  assign imm_s = XLEN'($signed({inst[31:25], inst[11:7]}));
  assign imm_b = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({inst[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));

  always_comb begin
    bundle           = '0;
    bundle.rs1       = inst[19:15];
    bundle.rs2       = inst[24:20];
    bundle.rd        = inst[11:7];
    bundle.alu_a_sel = 1'b1;
    bundle.alu_ctrl  = ALU_ADD;
    imm              = '0;

    case (opcode)
      OPC_LUI: begin
        bundle.rf_wr_en  = 1'b1;
        bundle.rf_wr_sel = RF_ALU;
        bundle.alu_b_sel = 1'b1;
        bundle.alu_ctrl  = ALU_LUI;
        imm              = imm_u;
      end
      OPC_AUIPC: begin
        bundle.rf_wr_en  = 1'b1;
        bundle.rf_wr_sel = RF_ALU;
        bundle.alu_a_sel = 1'b0;
        bundle.alu_b_sel = 1'b1;
        imm              = imm_u;
      end
      OPC_JAL: begin
        bundle.rf_wr_en  = 1'b1;
        bundle.rf_wr_sel = RF_PC4;
        bundle.do_jump   = 1'b1;
        bundle.alu_a_sel = 1'b0;
        bundle.alu_b_sel = 1'b1;
        imm              = imm_j;
      end
      OPC_JALR: begin
        bundle.rf_wr_en  = 1'b1;
        bundle.rf_wr_sel = RF_PC4;
        bundle.do_jump   = 1'b1;
        bundle.alu_b_sel = 1'b1;
        bundle.illegal   = (funct3 != 3'b000);
        imm              = imm_i;
      end
      OPC_BRANCH: begin
        // ALU forms the target pc+imm; the comparator works on rs1/rs2.
        bundle.alu_a_sel = 1'b0;
        bundle.alu_b_sel = 1'b1;
        imm              = imm_b;
        case (funct3)
          3'b000:  bundle.br_type = BR_BEQ;
          3'b001:  bundle.br_type = BR_BNE;
          3'b100:  bundle.br_type = BR_BLT;
          3'b101:  bundle.br_type = BR_BGE;
          3'b110:  bundle.br_type = BR_BLTU;
          3'b111:  bundle.br_type = BR_BGEU;
          default: bundle.illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        bundle.rf_wr_en  = 1'b1;
        bundle.rf_wr_sel = RF_MEM;
        bundle.alu_b_sel = 1'b1;
        imm              = imm_i;
        case (funct3)
          3'b000:  bundle.dm_rd_sel = DM_RD_LB;
          3'b001:  bundle.dm_rd_sel = DM_RD_LH;
          3'b010:  bundle.dm_rd_sel = DM_RD_LW;
          3'b100:  bundle.dm_rd_sel = DM_RD_LBU;
          3'b101:  bundle.dm_rd_sel = DM_RD_LHU;
          3'b110:  if (IS_RV64) bundle.dm_rd_sel = DM_RD_LWU; else bundle.illegal = 1'b1;
          3'b011:  if (IS_RV64) bundle.dm_rd_sel = DM_RD_LD;  else bundle.illegal = 1'b1;
          default: bundle.illegal = 1'b1;
        endcase
      end
      OPC_STORE: begin
        bundle.alu_b_sel = 1'b1;
        imm              = imm_s;
        case (funct3)
          3'b000:  bundle.dm_wr_sel = DM_WR_SB;
          3'b001:  bundle.dm_wr_sel = DM_WR_SH;
          3'b010:  bundle.dm_wr_sel = DM_WR_SW;
          3'b011:  if (IS_RV64) bundle.dm_wr_sel = DM_WR_SD; else bundle.illegal = 1'b1;
          default: bundle.illegal = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        bundle.rf_wr_en  = 1'b1;
        bundle.rf_wr_sel = RF_ALU;
        bundle.alu_b_sel = 1'b1;
        imm              = imm_i;
        case (funct3)
          3'b000: bundle.alu_ctrl = ALU_ADD;
          3'b010: bundle.alu_ctrl = ALU_SLT;
          3'b011: bundle.alu_ctrl = ALU_SLTU;
          3'b100: bundle.alu_ctrl = ALU_XOR;
          3'b110: bundle.alu_ctrl = ALU_OR;
          3'b111: bundle.alu_ctrl = ALU_AND;
          3'b001: begin
            // shamt is 6 bits on RV64; inst[25] must be clear on RV32
            imm             = XLEN'(inst[25:20]);
            bundle.alu_ctrl = ALU_SLL;
            if (inst[31:26] != 6'b000000 || (!IS_RV64 && inst[25])) bundle.illegal = 1'b1;
          end
          default: begin
            imm = XLEN'(inst[25:20]);
            if (inst[31:26] == 6'b000000)      bundle.alu_ctrl = ALU_SRL;
            else if (inst[31:26] == 6'b010000) bundle.alu_ctrl = ALU_SRA;
            else                               bundle.illegal  = 1'b1;
            if (!IS_RV64 && inst[25]) bundle.illegal = 1'b1;
          end
        endcase
      end
      OPC_OP_IMM32: begin
        bundle.rf_wr_en  = 1'b1;
        bundle.rf_wr_sel = RF_ALU;
        bundle.alu_b_sel = 1'b1;
        bundle.word      = 1'b1;
        imm              = imm_i;
        if (!IS_RV64) bundle.illegal = 1'b1;
        case (funct3)
          3'b000: bundle.alu_ctrl = ALU_ADD;
          3'b001: begin
            imm = XLEN'(inst[24:20]);
            if (funct7 == 7'b0000000) bundle.alu_ctrl = ALU_SLL;
            else                      bundle.illegal  = 1'b1;
          end
          3'b101: begin
            imm = XLEN'(inst[24:20]);
            if (funct7 == 7'b0000000)      bundle.alu_ctrl = ALU_SRL;
            else if (funct7 == 7'b0100000) bundle.alu_ctrl = ALU_SRA;
            else                           bundle.illegal  = 1'b1;
          end
          default: bundle.illegal = 1'b1;
        endcase
      end
      OPC_OP, OPC_OP_32: begin
        bundle.rf_wr_en  = 1'b1;
        bundle.rf_wr_sel = RF_ALU;
        bundle.word      = is_op32;
        if (is_op32 && !IS_RV64) bundle.illegal = 1'b1;
        if (funct7 == 7'b0000001) begin
          // M ops: *W forms exist only for mul/div/divu/rem/remu
          if (!M_ON || (is_op32 && (funct3 inside {3'b001, 3'b010, 3'b011})))
            bundle.illegal = 1'b1;
          else
            bundle.alu_ctrl = alu_ctrl_e'({2'b10, funct3});
        end else if (funct7 == 7'b0000000) begin
          // base register ops map funct3 directly onto the low ALU code bits
          if (is_op32 && !(funct3 inside {3'b000, 3'b001, 3'b101}))
            bundle.illegal = 1'b1;
          else
            bundle.alu_ctrl = alu_ctrl_e'({2'b00, funct3});
        end else if (funct7 == 7'b0100000) begin
          if (funct3 == 3'b000)      bundle.alu_ctrl = ALU_SUB;
          else if (funct3 == 3'b101) bundle.alu_ctrl = ALU_SRA;
          else                       bundle.illegal  = 1'b1;
        end else begin
          bundle.illegal = 1'b1;
        end
      end
      OPC_MISC_MEM: begin
        // fence: no architectural effect in this in-order core
        if (funct3 != 3'b000) bundle.illegal = 1'b1;
      end
      OPC_SYSTEM: begin
        if (inst == INST_ECALL)       bundle.ecall   = 1'b1;
        else if (inst == INST_EBREAK) bundle.ebreak  = 1'b1;
        else                          bundle.illegal = 1'b1;
      end
      default: bundle.illegal = 1'b1;
    endcase

    // Trapping instructions must have no architectural side effects.
    if (bundle.illegal || bundle.ecall || bundle.ebreak) begin
      bundle.rf_wr_en  = 1'b0;
      bundle.dm_wr_sel = DM_WR_NONE;
      bundle.do_jump   = 1'b0;
      bundle.br_type   = BR_NONE;
      bundle.alu_ctrl  = ALU_ADD;
    end
    if (bundle.rd == 5'd0) bundle.rf_wr_en = 1'b0;
  end

endmodule

// File: rtl/ysyx_decode_stage.sv
// ysyx_decode_stage
//   Decode stage between the IFU output register and the EXU. Decodes each
//   accepted instruction and holds the result in a 2-entry skid buffer so
//   EXU backpressure never reaches IFU combinationally.
//   Ports:
//     clk, rst                  clock, synchronous active-high reset
//     in_valid/in_ready         IFU handshake; in_inst, in_pc payload
//     flush                     squash all held entries (wins over push/pop)
//     out_valid/out_ready       EXU handshake
//     out_*                     oldest decoded bundle, its PC and immediate
module ysyx_decode_stage
  import ysyx_decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int HAS_M = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic            out_rf_wr_en,
  output logic [1:0]      out_rf_wr_sel,
  output logic            out_do_jump,
  output logic [2:0]      out_br_type,
  output logic            out_alu_a_sel,
  output logic            out_alu_b_sel,
  output logic [4:0]      out_alu_ctrl,
  output logic            out_word,
  output logic [2:0]      out_dm_rd_sel,
  output logic [2:0]      out_dm_wr_sel,
  output logic [XLEN-1:0] out_imm,
  output logic            out_illegal,
  output logic            out_ecall,
  output logic            out_ebreak
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    decode_bundle_t  ctl;
  } entry_t;

  decode_bundle_t  dec_bundle;
  logic [XLEN-1:0] dec_imm;

  ysyx_decode_comb #(
    .XLEN (XLEN),
    .HAS_M(HAS_M)
  ) u_decode_comb (
    .inst  (in_inst),
    .bundle(dec_bundle),
    .imm   (dec_imm)
  );

  logic [1:0] count_q, count_d;
  entry_t     head_q, head_d;   // oldest entry, always the one presented
  entry_t     tail_q, tail_d;   // skid slot, only valid when count is 2
  entry_t     new_entry;
  logic       push, pop;

  assign new_entry = '{pc: in_pc, imm: dec_imm, ctl: dec_bundle};

  // Both handshake outputs come straight from the count register.
  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) head_d = new_entry;
          else                 tail_d = new_entry;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          head_d  = tail_q;
          count_d = count_q - 2'd1;
        end
        // push and pop together only happens with exactly one entry held
        2'b11:   head_d = new_entry;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  assign out_pc        = head_q.pc;
  assign out_imm       = head_q.imm;
  assign out_rs1       = head_q.ctl.rs1;
  assign out_rs2       = head_q.ctl.rs2;
  assign out_rd        = head_q.ctl.rd;
  assign out_rf_wr_en  = head_q.ctl.rf_wr_en;
  assign out_rf_wr_sel = head_q.ctl.rf_wr_sel;
  assign out_do_jump   = head_q.ctl.do_jump;
  assign out_br_type   = head_q.ctl.br_type;
  assign out_alu_a_sel = head_q.ctl.alu_a_sel;
  assign out_alu_b_sel = head_q.ctl.alu_b_sel;
  assign out_alu_ctrl  = head_q.ctl.alu_ctrl;
  assign out_word      = head_q.ctl.word;
  assign out_dm_rd_sel = head_q.ctl.dm_rd_sel;
  assign out_dm_wr_sel = head_q.ctl.dm_wr_sel;
  assign out_illegal   = head_q.ctl.illegal;
  assign out_ecall     = head_q.ctl.ecall;
  assign out_ebreak    = head_q.ctl.ebreak;

endmodule

// File: tb/tb_ysyx_decode_stage.sv
// Directed bench for ysyx_decode_stage. Two instances share the stimulus:
// a_* is XLEN=32 without M, b_* is XLEN=64 with M.
module tb_ysyx_decode_stage;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, flush, out_ready;
  logic [31:0] in_inst;
  logic [63:0] pc;

  logic        a_in_ready, a_out_valid, a_rf_wr_en, a_do_jump, a_a_sel, a_b_sel, a_word;
  logic        a_illegal, a_ecall, a_ebreak;
  logic [31:0] a_pc, a_imm;
  logic [4:0]  a_rs1, a_rs2, a_rd, a_alu_ctrl;
  logic [1:0]  a_rf_wr_sel;
  logic [2:0]  a_br_type, a_dm_rd_sel, a_dm_wr_sel;

  logic        b_in_ready, b_out_valid, b_rf_wr_en, b_do_jump, b_a_sel, b_b_sel, b_word;
  logic        b_illegal, b_ecall, b_ebreak;
  logic [63:0] b_pc, b_imm;
  logic [4:0]  b_rs1, b_rs2, b_rd, b_alu_ctrl;
  logic [1:0]  b_rf_wr_sel;
  logic [2:0]  b_br_type, b_dm_rd_sel, b_dm_wr_sel;

  ysyx_decode_stage #(.XLEN(32), .HAS_M(0)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_inst(in_inst), .in_pc(pc[31:0]), .flush(flush),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_pc(a_pc),
    .out_rs1(a_rs1), .out_rs2(a_rs2), .out_rd(a_rd),
    .out_rf_wr_en(a_rf_wr_en), .out_rf_wr_sel(a_rf_wr_sel), .out_do_jump(a_do_jump),
    .out_br_type(a_br_type), .out_alu_a_sel(a_a_sel), .out_alu_b_sel(a_b_sel),
    .out_alu_ctrl(a_alu_ctrl), .out_word(a_word), .out_dm_rd_sel(a_dm_rd_sel),
    .out_dm_wr_sel(a_dm_wr_sel), .out_imm(a_imm), .out_illegal(a_illegal),
    .out_ecall(a_ecall), .out_ebreak(a_ebreak)
  );

  ysyx_decode_stage #(.XLEN(64), .HAS_M(1)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_inst(in_inst), .in_pc(pc), .flush(flush),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_pc(b_pc),
    .out_rs1(b_rs1), .out_rs2(b_rs2), .out_rd(b_rd),
    .out_rf_wr_en(b_rf_wr_en), .out_rf_wr_sel(b_rf_wr_sel), .out_do_jump(b_do_jump),
    .out_br_type(b_br_type), .out_alu_a_sel(b_a_sel), .out_alu_b_sel(b_b_sel),
    .out_alu_ctrl(b_alu_ctrl), .out_word(b_word), .out_dm_rd_sel(b_dm_rd_sel),
    .out_dm_wr_sel(b_dm_wr_sel), .out_imm(b_imm), .out_illegal(b_illegal),
    .out_ecall(b_ecall), .out_ebreak(b_ebreak)
  );

  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for a single cycle (buffer assumed empty, out_ready=1).
  task automatic send(input logic [31:0] inst, input logic [63:0] pcv);
    in_valid = 1'b1;
    in_inst  = inst;
    pc       = pcv;
    tick();
    in_valid = 1'b0;
    $display("send inst=%08h pc=%016h a_valid=%0b b_valid=%0b", inst, pcv, a_out_valid, b_out_valid);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_inst = 32'h0; pc = 64'h0;
    tick(); tick();
    chk("rst_hold_valid", 64'(a_out_valid), 64'd0);
    rst = 1'b0;
    tick();
    chk("rst_valid",   64'(a_out_valid), 64'd0);
    chk("rst_ready",   64'(a_in_ready),  64'd1);
    chk("rst_imm",     64'(a_imm),       64'd0);
    chk("rst_rd",      64'(a_rd),        64'd0);
    chk("rst_b_ready", 64'(b_in_ready),  64'd1);

    // addi x1,x0,5 : one cycle latency into an empty buffer
    send(32'h0050_0093, 64'h8000_0000);
    chk("addi_valid",   64'(a_out_valid),   64'd1);
    chk("addi_rd",      64'(a_rd),          64'd1);
    chk("addi_wr_en",   64'(a_rf_wr_en),    64'd1);
    chk("addi_wr_sel",  64'(a_rf_wr_sel),   64'd2);
    chk("addi_b_sel",   64'(a_b_sel),       64'd1);
    chk("addi_alu",     64'(a_alu_ctrl),    64'd0);
    chk("addi_imm",     64'(a_imm),         64'd5);
    chk("addi_pc",      64'(a_pc),          64'h8000_0000);
    tick();
    chk("addi_drained", 64'(a_out_valid),   64'd0);

    // Backpressure: A, B fill the buffer, C waits at the IFU.
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h0010_0113; pc = 64'h100;
    tick();
    chk("bp_one_valid", 64'(a_out_valid), 64'd1);
    chk("bp_one_ready", 64'(a_in_ready),  64'd1);
    in_inst = 32'h0020_0193; pc = 64'h104;
    tick();
    chk("bp_two_ready", 64'(a_in_ready),  64'd0);
    chk("bp_two_rd",    64'(a_rd),        64'd2);
    in_inst = 32'h0030_0213; pc = 64'h108;
    tick();
    $display("stall C a_ready=%0b a_rd=%0d", a_in_ready, a_rd);
    chk("bp_hold_ready", 64'(a_in_ready), 64'd0);
    chk("bp_hold_rd",    64'(a_rd),       64'd2);
    chk("bp_hold_pc",    64'(a_pc),       64'h100);
    out_ready = 1'b1;
    tick();
    chk("bp_pop1_rd",    64'(a_rd),       64'd3);
    chk("bp_pop1_ready", 64'(a_in_ready), 64'd1);
    tick();
    chk("bp_pop2_rd",    64'(a_rd),       64'd4);
    chk("bp_pop2_pc",    64'(a_pc),       64'h108);
    chk("bp_pop2_valid", 64'(a_out_valid), 64'd1);
    in_valid = 1'b0;
    tick();
    chk("bp_empty",      64'(a_out_valid), 64'd0);

    // Flush while full, with a simultaneous input that must be dropped.
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h0010_0113; pc = 64'h200;
    tick();
    in_inst = 32'h0020_0193; pc = 64'h204;
    tick();
    chk("fl_full", 64'(a_in_ready), 64'd0);
    flush = 1'b1; in_inst = 32'h0030_0213; pc = 64'h208;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    $display("flush a_valid=%0b a_ready=%0b", a_out_valid, a_in_ready);
    chk("fl_valid",   64'(a_out_valid), 64'd0);
    chk("fl_ready",   64'(a_in_ready),  64'd1);
    chk("fl_b_valid", 64'(b_out_valid), 64'd0);
    out_ready = 1'b1;
    tick();
    chk("fl_nothing", 64'(a_out_valid), 64'd0);

    // Decode vectors
    send(32'hFFFF_FFFF, 64'h300);
    chk("ones_illegal", 64'(a_illegal),  64'd1);
    chk("ones_wr_en",   64'(a_rf_wr_en), 64'd0);
    tick();
    send(32'h0010_0073, 64'h304);
    chk("ebreak",         64'(a_ebreak),  64'd1);
    chk("ebreak_illegal", 64'(a_illegal), 64'd0);
    chk("ebreak_ecall",   64'(a_ecall),   64'd0);
    tick();
    send(32'h0020_0073, 64'h308);
    chk("sys_illegal", 64'(a_illegal), 64'd1);
    chk("sys_ebreak",  64'(a_ebreak),  64'd0);
    tick();
    send(32'h0000_0073, 64'h30C);
    chk("ecall", 64'(a_ecall), 64'd1);
    tick();
    send(32'hFFC1_2083, 64'h310);
    chk("lw_b_imm",  b_imm,             64'hFFFF_FFFF_FFFF_FFFC);
    chk("lw_b_sel",  64'(b_dm_rd_sel),  64'd5);
    chk("lw_a_imm",  64'(a_imm),        64'h0000_0000_FFFF_FFFC);
    chk("lw_a_sel",  64'(a_dm_rd_sel),  64'd5);
    chk("lw_a_wsel", 64'(a_rf_wr_sel),  64'd3);
    tick();
    send(32'h0001_3083, 64'h314);
    chk("ld_b_sel",     64'(b_dm_rd_sel), 64'd7);
    chk("ld_b_illegal", 64'(b_illegal),   64'd0);
    chk("ld_a_illegal", 64'(a_illegal),   64'd1);
    tick();
    send(32'h0220_81B3, 64'h318);
    chk("mul_b_alu",     64'(b_alu_ctrl),  64'h10);
    chk("mul_b_wr_sel",  64'(b_rf_wr_sel), 64'd2);
    chk("mul_b_rd",      64'(b_rd),        64'd3);
    chk("mul_b_wr_en",   64'(b_rf_wr_en),  64'd1);
    chk("mul_a_illegal", 64'(a_illegal),   64'd1);
    chk("mul_a_wr_en",   64'(a_rf_wr_en),  64'd0);
    tick();
    send(32'h0200_9093, 64'h31C);   // slli x1,x1,32
    chk("slli32_a_illegal", 64'(a_illegal), 64'd1);
    chk("slli32_b_illegal", 64'(b_illegal), 64'd0);
    chk("slli32_b_imm",     b_imm,          64'd32);
    tick();
    send(32'h4030_D093, 64'h320);   // srai x1,x1,3
    chk("srai_alu", 64'(a_alu_ctrl), 64'h0D);
    chk("srai_imm", 64'(a_imm),      64'd3);
    tick();
    send(32'h0000_0013, 64'h324);   // nop: rd=x0
    chk("nop_wr_en",   64'(a_rf_wr_en), 64'd0);
    chk("nop_illegal", 64'(a_illegal),  64'd0);
    tick();
    send(32'h8000_02B7, 64'h328);   // lui x5,0x80000
    chk("lui_b_imm", b_imm,             64'hFFFF_FFFF_8000_0000);
    chk("lui_b_alu", 64'(b_alu_ctrl),   64'h0E);
    chk("lui_b_rd",  64'(b_rd),         64'd5);
    tick();
    send(32'h0011_3023, 64'h32C);   // sd x1,0(x2)
    chk("sd_b_wr",      64'(b_dm_wr_sel), 64'd4);
    chk("sd_a_illegal", 64'(a_illegal),   64'd1);
    chk("sd_a_wr",      64'(a_dm_wr_sel), 64'd0);
    tick();
    send(32'hFE20_9CE3, 64'h330);   // bne x1,x2,-8
    chk("bne_type",  64'(a_br_type),  64'd3);
    chk("bne_imm",   64'(a_imm),      64'h0000_0000_FFFF_FFF8);
    chk("bne_wr_en", 64'(a_rf_wr_en), 64'd0);
    chk("bne_a_sel", 64'(a_a_sel),    64'd0);
    tick();
    chk("end_empty", 64'(a_out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ysyx_decode_stage.md
Name: ysyx_decode_stage

Overview:
- Pipelined, parametrised instruction-decode stage for the NPC core; sits between the IFU output register and the EXU.
- Accepts one fetched instruction per cycle over a valid/ready handshake and fully decodes it.
- Decode covers the full RV32I/RV64I base set, optional M extension, ecall/ebreak and illegal detection.
- Decoded control bundle is registered behind a 2-entry skid buffer, so backpressure from EXU never forms a combinational path to IFU.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64 (64 enables ld/lwu/sd and *W ops).
- HAS_M, 0, 1 enables decode of M-extension mul/div/rem ops.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  IFU has an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_inst  in  32  instruction word.
- in_pc  in  XLEN  instruction PC.
- flush  in  1  squash all held entries (redirect).
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  EXU accepts bundle.
- out_pc  out  XLEN  PC of bundle.
- out_rs1, out_rs2, out_rd  out  5 each  register indices.
- out_rf_wr_en  out  1  writes rd.
- out_rf_wr_sel  out  2  00 none, 01 pc+4, 10 alu, 11 mem.
- out_do_jump  out  1  jal/jalr.
- out_br_type  out  3  0 none, 010 beq, 011 bne, 100 blt, 101 bge, 110 bltu, 111 bgeu.
- out_alu_a_sel, out_alu_b_sel  out  1 each  0=pc/1=rs1; 0=rs2/1=imm.
- out_alu_ctrl  out  5  bit4=0 base codes (add 0000, sll 0001, slt 0010, sltu 0011, xor 0100, srl 0101, or 0110, and 0111, sub 1000, sra 1101, lui 1110); bit4=1 M op, low 3 bits = funct3.
- out_word  out  1  RV64 *W op (result sign-extended from 32 bits).
- out_dm_rd_sel  out  3  001 lb, 010 lbu, 011 lh, 100 lhu, 101 lw, 110 lwu, 111 ld.
- out_dm_wr_sel  out  3  001 sb, 010 sh, 011 sw, 100 sd.
- out_imm  out  XLEN  sign-extended immediate (I/S/B/U/J per format).
- out_illegal, out_ecall, out_ebreak  out  1 each  exception flags.

Behaviour:
- Latency: 1 cycle from in_valid&&in_ready to out_valid, when the buffer is empty.
- Buffer states:
  - EMPTY: in_ready=1, out_valid=0.
  - ONE: out_valid=1, in_ready=1.
  - TWO (skid): out_valid=1, in_ready=0.
- Transitions:
  - push only: count+1.
  - pop only (out_valid&&out_ready): count-1.
  - push and pop in the same cycle: count unchanged, order preserved.
  - EXU always sees the oldest entry.
- in_ready is a pure register-derived signal (count<2); no combinational dependence on out_ready.
- flush:
  - next cycle count=0 and out_valid=0.
  - a simultaneous input handshake is dropped.
  - flush has priority over push and pop.
- Reset: count=0, out_valid=0, in_ready=1 the cycle after rst deasserts; all payload registers 0.
- Payload held stable while out_valid&&!out_ready.
- Decode is combinational on in_inst and is captured at push.
- Illegal cases:
  - unknown opcode/funct3/funct7.
  - slli/srli/srai with inst[25]=1 when XLEN=32.
  - 64-bit-only ops (ld, lwu, sd, *W) when XLEN=32.
  - M ops when HAS_M=0.
  - any SYSTEM encoding other than exactly 0x00000073 (ecall) or 0x00100073 (ebreak).
- When illegal, ecall or ebreak: rf_wr_en=0, dm_wr_sel=0, do_jump=0, br_type=0, alu_ctrl=0.
- Exception flags are mutually exclusive.
- rf_wr_en forced 0 when rd=0.
- Immediates:
  - sign-extended from inst[31] to XLEN.
  - U-type = inst[31:12]<<12, sign-extended to XLEN.
  - shift immediates carry shamt in imm[5:0].

Decomposition:
- Package ysyx_decode_pkg holds:
  - opcode localparams.
  - alu_ctrl, br_type, rf_wr_sel, dm_rd_sel and dm_wr_sel encodings as typed enums.
  - a packed struct decode_bundle_t, parametrised-width fields excluded.
- One sub-module, ysyx_decode_comb: purely combinational inst→bundle decoder, parameters XLEN/HAS_M.
- Top module contains only the skid buffer, count state and flush logic.

Test Plan:
- addi x1,x0,5 (0x00500093), pc 0x80000000, out_ready=1 → next cycle out_valid=1, rd=1, rf_wr_en=1, rf_wr_sel=10, alu_b_sel=1, alu_ctrl=00000, imm=5.
- out_ready=0, three back-to-back valid instructions → first two accepted, in_ready=0 after second, third held at IFU; raise out_ready → bundles emerge in program order over 2 cycles, then third accepted.
- Buffer in TWO, flush=1 with in_valid=1 → next cycle out_valid=0, in_ready=1; input dropped, nothing later emerges.
- 0xFFFFFFFF → out_illegal=1, rf_wr_en=0; 0x00100073 → out_ebreak=1; 0x00200073 → out_illegal=1, out_ebreak=0.
- XLEN=64: lw x1,-4(x2) 0xFFC12083 → imm=0xFFFFFFFFFFFFFFFC, dm_rd_sel=101; ld 0x00013083 → dm_rd_sel=111. Under XLEN=32 the ld → out_illegal=1.
- mul x3,x1,x2 0x022081B3: HAS_M=1 → alu_ctrl=10000, rf_wr_sel=10, rd=3; HAS_M=0 → out_illegal=1, rf_wr_en=0.
